// File: rtl/prog_sequence_detector_if.sv
// Bundles the configuration, serial data and status signals of the programmable
// sequence detector so that the bench drives one master view and the core one slave view.
interface prog_sequence_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               din;
    logic               din_valid;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_value;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;
    logic               armed;
    logic               cfg_err;

    modport master (
        output din, din_valid, pat_load, pat_value, pat_len, overlap_en, cnt_clr,
        input  out, match_cnt, cnt_sat, armed, cfg_err
    );

    modport slave (
        input  din, din_valid, pat_load, pat_value, pat_len, overlap_en, cnt_clr,
        output out, match_cnt, cnt_sat, armed, cfg_err
    );
endinterface

// File: rtl/prog_sequence_detector.sv
// Serial pattern matcher with a run-time loadable pattern of 1..MAX_LEN bits,
// selectable overlapping detection and a saturating match counter.
module prog_sequence_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    prog_sequence_detector_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] hist_new;
    logic [LEN_W-1:0]   fill_new;
    logic [MAX_LEN:0]   mask_ext;
    logic [MAX_LEN-1:0] mask;
    logic               legal;
    logic               match;

    // Only the low len_q history bits take part in the compare.
    assign mask_ext = ({{MAX_LEN{1'b0}}, 1'b1} << len_q) - 1'b1;
    assign mask     = mask_ext[MAX_LEN-1:0];
    assign hist_new = {hist_q[MAX_LEN-2:0], bus.din};
    assign fill_new = (fill_q == LEN_MAX) ? LEN_MAX : fill_q + 1'b1;
    assign legal    = (bus.pat_len != '0) && (bus.pat_len <= LEN_MAX);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = err_q;
        out_d   = 1'b0;
        match   = 1'b0;

        if (bus.pat_load) begin
            hist_d = '0;
            fill_d = '0;
            if (legal) begin
                pat_d   = bus.pat_value;
                len_d   = bus.pat_len;
                ovl_d   = bus.overlap_en;
                err_d   = 1'b0;
                state_d = RUN;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == RUN && bus.din_valid) begin
            match  = (fill_new >= len_q) && (((hist_new ^ pat_q) & mask) == '0);
            hist_d = hist_new;
            // Non-overlapping mode restarts the fill so no matched bit is reused.
            fill_d = (match && !ovl_q) ? '0 : fill_new;
            out_d  = match;
        end

        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (match && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
    assign bus.armed     = (state_q == RUN);
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_prog_sequence_detector.sv
// Directed and randomized checks of prog_sequence_detector against a queue-based
// model of received bits.
module tb_prog_sequence_detector;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    prog_sequence_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    prog_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit   m_armed, m_err, m_ovl, m_out;
    int   m_len, m_cnt;
    logic [MAX_LEN-1:0] m_pat;
    bit   m_bits[$];
    int   pulses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_err = 0; m_ovl = 0; m_out = 0;
        m_len = 0; m_cnt = 0; m_pat = '0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit d, input bit v, input bit ld,
                              input logic [MAX_LEN-1:0] pv, input int pl,
                              input bit ov, input bit clr);
        bit hit;
        hit   = 0;
        m_out = 0;
        if (ld) begin
            m_bits.delete();
            if (pl >= 1 && pl <= MAX_LEN) begin
                m_pat = pv; m_len = pl; m_ovl = ov; m_armed = 1; m_err = 0;
            end else begin
                m_armed = 0; m_err = 1;
            end
        end else if (m_armed && v) begin
            m_bits.push_back(d);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                hit = 1;
                // oldest of the last m_len bits must equal pattern bit m_len-1
                for (int i = 0; i < m_len; i++)
                    if (m_bits[m_bits.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
            end
            if (hit) begin
                m_out = 1;
                if (!m_ovl) m_bits.delete();
            end
        end
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},   32'(bus.out),       32'(m_out));
        chk({tag, ".cnt"},   32'(bus.match_cnt), 32'(m_cnt));
        chk({tag, ".sat"},   32'(bus.cnt_sat),   32'(m_cnt == (1 << CNT_W) - 1));
        chk({tag, ".armed"}, 32'(bus.armed),     32'(m_armed));
        chk({tag, ".err"},   32'(bus.cfg_err),   32'(m_err));
    endtask

    // Inputs change just after a falling edge; outputs are checked on the next falling edge.
    task automatic step(input string tag, input bit d, input bit v, input bit ld,
                        input logic [MAX_LEN-1:0] pv, input int pl,
                        input bit ov, input bit clr);
        bus.din = d; bus.din_valid = v; bus.pat_load = ld; bus.pat_value = pv;
        bus.pat_len = LEN_W'(pl); bus.overlap_en = ov; bus.cnt_clr = clr;
        @(posedge clk);
        model_step(d, v, ld, pv, pl, ov, clr);
        @(negedge clk);
        if (bus.out === 1'b1) pulses++;
        check_all(tag);
        bus.pat_load = 0; bus.cnt_clr = 0; bus.din_valid = 0;
    endtask

    task automatic load(input string tag, input logic [MAX_LEN-1:0] pv, input int pl, input bit ov);
        step(tag, 1'b1, 1'b1, 1'b1, pv, pl, ov, 1'b0);
    endtask

    task automatic bit_in(input string tag, input bit d, input bit v);
        step(tag, d, v, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic clear(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        bit stream[7];
        stream = '{1, 0, 1, 1, 0, 1, 1};
        bus.din = 0; bus.din_valid = 0; bus.pat_load = 0; bus.pat_value = '0;
        bus.pat_len = '0; bus.overlap_en = 0; bus.cnt_clr = 0;
        model_reset();
        rstn = 0;
        #1;
        check_all("rst_async");
        repeat (2) @(negedge clk);
        rstn = 1;
        check_all("rst_idle");
        bit_in("idle_ignore", 1'b1, 1'b1);

        // overlapping 1011
        load("ld_ovl", 8'b1011, 4, 1'b1);
        pulses = 0;
        foreach (stream[i]) bit_in("ovl_stream", stream[i], 1'b1);
        chk("ovl_pulses", 32'(pulses), 32'd2);
        chk("ovl_cnt", 32'(bus.match_cnt), 32'd2);
        clear("clr1");

        // non-overlapping 1011
        load("ld_novl", 8'b1011, 4, 1'b0);
        pulses = 0;
        foreach (stream[i]) bit_in("novl_stream", stream[i], 1'b1);
        chk("novl_pulses", 32'(pulses), 32'd1);
        chk("novl_cnt", 32'(bus.match_cnt), 32'd1);
        clear("clr2");

        // saturation with a one-bit pattern
        load("ld_len1", 8'b1, 1, 1'b1);
        repeat (300) bit_in("sat_stream", 1'b1, 1'b1);
        chk("sat_cnt", 32'(bus.match_cnt), 32'd255);
        chk("sat_flag", 32'(bus.cnt_sat), 32'd1);
        // clear wins over a simultaneous match, pulse still fires
        step("clr_vs_match", 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
        chk("clr_cnt", 32'(bus.match_cnt), 32'd0);
        chk("clr_sat", 32'(bus.cnt_sat), 32'd0);

        // illegal lengths
        load("ld_len0", 8'hFF, 0, 1'b1);
        chk("len0_err", 32'(bus.cfg_err), 32'd1);
        chk("len0_armed", 32'(bus.armed), 32'd0);
        pulses = 0;
        repeat (20) bit_in("len0_stream", 1'($urandom_range(0, 1)), 1'b1);
        chk("len0_pulses", 32'(pulses), 32'd0);
        load("ld_len9", 8'hFF, 9, 1'b1);
        load("ld_len8", 8'hA5, 8, 1'b1);

        // gaps in din_valid, then async reset mid-stream
        load("ld_110", 8'b110, 3, 1'b0);
        pulses = 0;
        bit_in("gap_b1", 1'b1, 1'b1);
        bit_in("gap_b2", 1'b1, 1'b1);
        repeat (5) bit_in("gap_idle", 1'b0, 1'b0);
        bit_in("gap_b3", 1'b0, 1'b1);
        chk("gap_pulses", 32'(pulses), 32'd1);
        bit_in("pre_rst", 1'b1, 1'b1);
        #2 rstn = 0;
        model_reset();
        #1;
        check_all("rst_mid");
        @(negedge clk);
        rstn = 1;
        repeat (3) bit_in("post_rst", 1'b1, 1'b1);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                int pl;
                pl = (r == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(1, 4));
                load("rnd_ld", MAX_LEN'($urandom), pl, 1'($urandom_range(0, 1)));
            end else if (r < 6) begin
                step("rnd_clr", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'b0, '0, 0, 1'b0, 1'b1);
            end else begin
                bit_in("rnd_bit", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_sequence_detector.md
PROG_SEQUENCE_DETECTOR -- requirements
Module: prog_sequence_detector

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 8, SHALL set the match counter width (1..16).
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN+1), SHALL set the pat_len width.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 din  input  1  SHALL be the serial data bit.
REQ-007 din_valid  input  1  SHALL qualify din; din is sampled only when din_valid=1.
REQ-008 pat_load  input  1  SHALL load pat_value, pat_len and overlap_en when high.
REQ-009 pat_value  input  MAX_LEN  SHALL hold the pattern; bit pat_len-1 is the first bit received.
REQ-010 pat_len  input  LEN_W  SHALL hold the pattern length.
REQ-011 overlap_en  input  1  SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-012 cnt_clr  input  1  SHALL synchronously clear match_cnt and cnt_sat.
REQ-013 out  output  1  SHALL be a registered one-cycle match pulse.
REQ-014 match_cnt  output  CNT_W  SHALL be the saturating count of matches.
REQ-015 cnt_sat  output  1  SHALL be high while match_cnt is at its maximum.
REQ-016 armed  output  1  SHALL be high in state RUN.
REQ-017 cfg_err  output  1  SHALL be high when the last load had an illegal pat_len.

Function
REQ-018 FSM SHALL have two states: IDLE (no valid pattern) and RUN (detecting).
REQ-019 pat_load with 1<=pat_len<=MAX_LEN SHALL register pattern/length/mode, clear history and fill count, clear cfg_err, go to RUN.
REQ-020 pat_load with pat_len=0 or >MAX_LEN SHALL go to IDLE, set cfg_err, clear history and fill count.
REQ-021 pat_load SHALL take effect from any state; din in the same cycle SHALL be discarded.
REQ-022 In RUN with din_valid=1: history SHALL shift left with din entering bit 0; fill count SHALL increment, saturating at MAX_LEN.
REQ-023 Match SHALL be: new fill >= stored len AND new history[len-1:0] == stored pattern[len-1:0].
REQ-024 out SHALL be 1 in the cycle after the edge sampling the completing bit, for exactly one cycle, otherwise 0.
REQ-025 din_valid=0 cycles SHALL not alter history, fill count or out (out=0).
REQ-026 overlap_en=1: after a match, history and fill SHALL be retained.
REQ-027 overlap_en=0: after a match, fill count SHALL reset to 0 so no bit is reused.
REQ-028 Each match SHALL increment match_cnt by 1, saturating at 2^CNT_W-1; cnt_sat SHALL be set when the value reaches the maximum.
REQ-029 cnt_clr SHALL take priority over a simultaneous match: match_cnt=0, cnt_sat=0; out still pulses.
REQ-030 cnt_clr SHALL be honoured in IDLE and RUN; pat_load SHALL not alter match_cnt.
REQ-031 In IDLE, din SHALL be ignored and out SHALL stay 0.

Reset
REQ-032 rstn=0 SHALL immediately force: state IDLE, out=0, match_cnt=0, cnt_sat=0, armed=0, cfg_err=0, history=0, fill=0, stored pattern/len/mode=0.
REQ-033 After rstn deassertion the block SHALL remain IDLE until a legal pat_load.

Verification
REQ-034 Load 1011, len 4, overlap_en=1; stream 1,0,1,1,0,1,1 all valid -> out pulses after bits 4 and 7; match_cnt=2.
REQ-035 Same load with overlap_en=0, same stream -> single pulse after bit 4; match_cnt=1.
REQ-036 Load 1, len 1; 300 consecutive valid 1s -> match_cnt=255, cnt_sat=1; cnt_clr then -> 0/0.
REQ-037 Load len 0 -> cfg_err=1, armed=0; any stream -> out never asserts.
REQ-038 Load 110, len 3; stream 1,1 then din_valid=0 for 5 cycles then 0 -> one pulse after the 0; assert rstn=0 mid-stream -> all outputs 0 at once, IDLE.
